// File: rtl/mc_pkg.sv
// Shared types and address-map constants for the memory-controller front end.
// The request queue and the downstream scheduler both use mc_req_t.
package mc_pkg;

    localparam int MC_CYC_W  = 64;
    localparam int ADDR_W    = 34;
    localparam int CORE_W    = 3;

    // Physical address to DIMM coordinate mapping
    localparam int CH_BIT    = 6;
    localparam int BG_LSB    = 7;
    localparam int BG_W      = 3;
    localparam int BANK_LSB  = 10;
    localparam int BANK_W    = 2;
    localparam int COLH_LSB  = 12;
    localparam int COLH_W    = 6;
    localparam int COLL_LSB  = 2;
    localparam int COLL_W    = 4;
    localparam int ROW_LSB   = 18;
    localparam int ROW_W     = 16;
    localparam int COL_W     = COLH_W + COLL_W;

    // Encoding 3 is illegal and deliberately absent from the enum
    typedef enum logic [1:0] {
        OPN_RD = 2'd0,
        OPN_WR = 2'd1,
        OPN_IF = 2'd2
    } opn_t;

    localparam logic [1:0] OPN_ILLEGAL = 2'd3;

    typedef struct packed {
        logic [CORE_W-1:0]   core;
        logic                is_write;
        logic                channel;
        logic [BG_W-1:0]     bank_group;
        logic [BANK_W-1:0]   bank;
        logic [ROW_W-1:0]    row;
        logic [COL_W-1:0]    column;
        logic [ADDR_W-1:0]   addr;
        logic [MC_CYC_W-1:0] enq_cyc;
    } mc_req_t;

endpackage

// File: rtl/mc_request_queue_if.sv
// Request-in and request-out handshakes of the queue.
// slave: the queue side; master: the CPU/scheduler side driving it.
interface mc_request_queue_if
    import mc_pkg::*;
#(
    parameter int CYC_W = MC_CYC_W
);
    logic                 in_valid;
    logic                 in_ready;
    logic [CORE_W-1:0]    in_core;
    logic [1:0]           in_opn;
    logic [ADDR_W-1:0]    in_addr;

    logic                 out_valid;
    logic                 out_ready;
    logic [CORE_W-1:0]    out_core;
    logic                 out_is_write;
    logic                 out_channel;
    logic [BG_W-1:0]      out_bank_group;
    logic [BANK_W-1:0]    out_bank;
    logic [ROW_W-1:0]     out_row;
    logic [COL_W-1:0]     out_column;
    logic [ADDR_W-1:0]    out_addr;
    logic [CYC_W-1:0]     out_enq_cyc;

    modport slave (
        input  in_valid, in_core, in_opn, in_addr, out_ready,
        output in_ready, out_valid, out_core, out_is_write, out_channel,
               out_bank_group, out_bank, out_row, out_column, out_addr,
               out_enq_cyc
    );

    modport master (
        output in_valid, in_core, in_opn, in_addr, out_ready,
        input  in_ready, out_valid, out_core, out_is_write, out_channel,
               out_bank_group, out_bank, out_row, out_column, out_addr,
               out_enq_cyc
    );
endinterface

// File: rtl/mc_addr_decode.sv
// Combinational address/opn decode into a request record (stamp left zero).
module mc_addr_decode
    import mc_pkg::*;
(
    input  logic [CORE_W-1:0] i_core,
    input  logic [1:0]        i_opn,
    input  logic [ADDR_W-1:0] i_addr,
    output mc_req_t           o_req,
    output logic              o_legal
);
    // Field extraction; instruction fetches are treated as reads
    always_comb begin
        o_req            = '0;
        o_req.core       = i_core;
        o_req.is_write   = (i_opn == OPN_WR);
        o_req.channel    = i_addr[CH_BIT];
        o_req.bank_group = i_addr[BG_LSB +: BG_W];
        o_req.bank       = i_addr[BANK_LSB +: BANK_W];
        o_req.row        = i_addr[ROW_LSB +: ROW_W];
        o_req.column     = {i_addr[COLH_LSB +: COLH_W], i_addr[COLL_LSB +: COLL_W]};
        o_req.addr       = i_addr;
        o_legal          = (i_opn != OPN_ILLEGAL);
    end
endmodule

// File: rtl/mc_request_queue.sv
// In-order request queue: decodes at acceptance, stamps with the cycle
// counter and presents the head entry to the command scheduler.
module mc_request_queue
    import mc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CYC_W = MC_CYC_W
) (
    input  logic                       clk,
    input  logic                       rst,
    mc_request_queue_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       err_bad_opn
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    mc_req_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [CYC_W-1:0]   r_cyc;
    logic               r_err;

    mc_req_t            w_dec;
    mc_req_t            w_entry;
    logic               w_legal;
    logic               w_push;
    logic               w_store;
    logic               w_pop;

    mc_addr_decode u_decode (
        .i_core  (bus.in_core),
        .i_opn   (bus.in_opn),
        .i_addr  (bus.in_addr),
        .o_req   (w_dec),
        .o_legal (w_legal)
    );

    assign full         = (r_count == CNT_W'(DEPTH));
    assign empty        = (r_count == '0);
    assign count        = r_count;
    assign err_bad_opn  = r_err;
    assign bus.in_ready = !full;
    assign bus.out_valid = !empty;

    assign w_push  = bus.in_valid && bus.in_ready;
    assign w_store = w_push && w_legal;
    assign w_pop   = bus.out_valid && bus.out_ready;

    // Attach the arrival stamp to the decoded request
    always_comb begin
        w_entry         = w_dec;
        w_entry.enq_cyc = r_cyc;
    end

    // Entry storage; contents survive reset, only pointers are cleared
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_tail] <= w_entry;
        end
    end

    // Pointers, occupancy, cycle counter and illegal-request pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_cyc   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_cyc <= r_cyc + CYC_W'(1);
            r_err <= w_push && !w_legal;
            if (w_store) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry straight from storage
    assign bus.out_core       = r_mem[r_head].core;
    assign bus.out_is_write   = r_mem[r_head].is_write;
    assign bus.out_channel    = r_mem[r_head].channel;
    assign bus.out_bank_group = r_mem[r_head].bank_group;
    assign bus.out_bank       = r_mem[r_head].bank;
    assign bus.out_row        = r_mem[r_head].row;
    assign bus.out_column     = r_mem[r_head].column;
    assign bus.out_addr       = r_mem[r_head].addr;
    assign bus.out_enq_cyc    = r_mem[r_head].enq_cyc;

endmodule

// File: tb/tb_mc_request_queue.sv
// Scoreboard bench for mc_request_queue: expected entries are queued at
// acceptance and compared field by field when the head is consumed.
module tb_mc_request_queue;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       err_bad_opn;

    mc_request_queue_if #(.CYC_W(64)) ifc ();

    mc_request_queue #(.DEPTH(16), .CYC_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (ifc),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .err_bad_opn (err_bad_opn)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  core;
        logic        is_write;
        logic        channel;
        logic [2:0]  bank_group;
        logic [1:0]  bank;
        logic [15:0] row;
        logic [9:0]  column;
        logic [33:0] addr;
        logic [63:0] enq_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] tb_cyc  = '0;
    logic        exp_err = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] core, input logic [1:0] opn,
                                   input logic [33:0] a, input logic [63:0] cyc);
        exp_t e;
        e.core       = core;
        e.is_write   = (opn == 2'd1);
        e.channel    = a[6];
        e.bank_group = a[9:7];
        e.bank       = a[11:10];
        e.row        = a[33:18];
        e.column     = {a[17:12], a[5:2]};
        e.addr       = a;
        e.enq_cyc    = cyc;
        return e;
    endfunction

    // One clock: check state, account handshakes, advance, update the model
    task automatic clk_step();
        logic was_rst, do_push, do_pop;
        exp_t e;
        was_rst = rst;
        do_push = !rst && ifc.in_valid && ifc.in_ready;
        do_pop  = !rst && ifc.out_valid && ifc.out_ready;
        if (!rst) begin
            check("count", 64'(count), 64'(sb.size()));
            check("in_ready", 64'(ifc.in_ready), 64'(sb.size() != 16));
            check("out_valid", 64'(ifc.out_valid), 64'(sb.size() != 0));
            check("empty", 64'(empty), 64'(sb.size() == 0));
            check("err_bad_opn", 64'(err_bad_opn), 64'(exp_err));
        end
        if (do_pop) begin
            if (sb.size() == 0) begin
                check("pop_underflow", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                $display("pop core=%0d wr=%0b addr=%09h stamp=%0d",
                         ifc.out_core, ifc.out_is_write, ifc.out_addr, ifc.out_enq_cyc);
                check("out_core", 64'(ifc.out_core), 64'(e.core));
                check("out_is_write", 64'(ifc.out_is_write), 64'(e.is_write));
                check("out_channel", 64'(ifc.out_channel), 64'(e.channel));
                check("out_bank_group", 64'(ifc.out_bank_group), 64'(e.bank_group));
                check("out_bank", 64'(ifc.out_bank), 64'(e.bank));
                check("out_row", 64'(ifc.out_row), 64'(e.row));
                check("out_column", 64'(ifc.out_column), 64'(e.column));
                check("out_addr", 64'(ifc.out_addr), 64'(e.addr));
                check("out_enq_cyc", ifc.out_enq_cyc, e.enq_cyc);
            end
        end
        if (do_push && ifc.in_opn != 2'd3) begin
            sb.push_back(model(ifc.in_core, ifc.in_opn, ifc.in_addr, tb_cyc));
        end
        @(posedge clk);
        #1;
        exp_err = do_push && (ifc.in_opn == 2'd3);
        if (was_rst) begin
            tb_cyc = '0;
            sb.delete();
            exp_err = 1'b0;
        end else begin
            tb_cyc = tb_cyc + 64'd1;
        end
    endtask

    task automatic set_req(input logic v, input logic [2:0] core, input logic [1:0] opn,
                           input logic [33:0] a);
        ifc.in_valid = v;
        ifc.in_core  = core;
        ifc.in_opn   = opn;
        ifc.in_addr  = a;
    endtask

    task automatic set_rand_req(input logic [1:0] opn);
        set_req(1'b1, 3'($urandom_range(7)), opn, {2'($urandom), 32'($urandom)});
    endtask

    task automatic drain();
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) clk_step();
        check("drained", 64'(sb.size()), 64'(0));
        ifc.out_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"}, 64'(empty), 64'(1));
        check({tag, "_full"}, 64'(full), 64'(0));
        check({tag, "_count"}, 64'(count), 64'(0));
        check({tag, "_out_valid"}, 64'(ifc.out_valid), 64'(0));
        check({tag, "_in_ready"}, 64'(ifc.in_ready), 64'(1));
        check({tag, "_err"}, 64'(err_bad_opn), 64'(0));
    endtask

    initial begin
        set_req(1'b0, 3'd0, 2'd0, 34'd0);
        ifc.out_ready = 1'b0;

        // Power-on reset
        rst = 1'b1;
        repeat (3) clk_step();
        rst = 1'b0;
        check_reset_state("por");

        // Decode: push at counter value 7
        for (int i = 0; i < 20 && tb_cyc != 64'd7; i++) clk_step();
        set_req(1'b1, 3'd5, 2'd0, 34'h1_2345_6789);
        clk_step();
        ifc.in_valid = 1'b0;
        check("dec_out_valid", 64'(ifc.out_valid), 64'(1));
        check("dec_channel", 64'(ifc.out_channel), 64'(0));
        check("dec_bank_group", 64'(ifc.out_bank_group), 64'(7));
        check("dec_bank", 64'(ifc.out_bank), 64'(1));
        check("dec_row", 64'(ifc.out_row), 64'h48D1);
        check("dec_column", 64'(ifc.out_column), 64'h162);
        check("dec_is_write", 64'(ifc.out_is_write), 64'(0));
        check("dec_core", 64'(ifc.out_core), 64'(5));
        check("dec_enq_cyc", ifc.out_enq_cyc, 64'd7);
        drain();

        // Fill to 16, 17th held off until one pop
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_rand_req(2'($urandom_range(2)));
            clk_step();
        end
        set_rand_req(2'd1);
        check("fill_count", 64'(count), 64'd16);
        check("fill_full", 64'(full), 64'(1));
        check("fill_in_ready", 64'(ifc.in_ready), 64'(0));
        clk_step();
        ifc.out_ready = 1'b1;
        clk_step();
        ifc.out_ready = 1'b0;
        check("after_pop_in_ready", 64'(ifc.in_ready), 64'(1));
        clk_step();
        check("refill_count", 64'(count), 64'd16);
        drain();

        // Simultaneous push/pop at occupancy 8 across pointer wrap
        for (int i = 0; i < 8; i++) begin
            set_rand_req(2'($urandom_range(2)));
            clk_step();
        end
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_rand_req(2'($urandom_range(2)));
            clk_step();
            check("simul_count", 64'(count), 64'd8);
        end
        drain();

        // Illegal opn into an empty queue, then a legal push
        set_rand_req(2'd3);
        clk_step();
        check("bad_err_pulse", 64'(err_bad_opn), 64'(1));
        check("bad_empty", 64'(empty), 64'(1));
        set_rand_req(2'd1);
        clk_step();
        ifc.in_valid = 1'b0;
        check("bad_err_clear", 64'(err_bad_opn), 64'(0));
        check("bad_then_legal_count", 64'(count), 64'd1);
        drain();

        // Instruction fetches interleaved with writes
        for (int i = 0; i < 6; i++) begin
            set_rand_req((i % 2 == 0) ? 2'd1 : 2'd2);
            clk_step();
        end
        drain();

        // Reset in the middle of traffic
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_rand_req(2'($urandom_range(3)));
            ifc.out_ready = (i % 3 == 2);
            clk_step();
        end
        rst = 1'b1;
        set_rand_req(2'd0);
        repeat (3) clk_step();
        rst = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        check_reset_state("midrst");
        set_rand_req(2'd0);
        clk_step();
        check("midrst_stamp", ifc.out_enq_cyc, 64'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_request_queue.md
# mc_request_queue

Synthesizable front end of the DDR5 memory controller. It accepts CPU memory requests (core, operation, 34-bit physical address) over a valid/ready handshake and decodes each address into DIMM coordinates. Decoded requests are held in a 16-entry in-order queue, and the head entry is presented to the downstream command scheduler (ACT0/ACT1/RD/WR/PRE issue) over a second valid/ready handshake. Each entry carries its arrival-cycle stamp so the scheduler can apply age-based policy.

## Interface
- DEPTH, 16, queue entries; power of 2, at least 2
- CYC_W, 64, width of the free-running cycle counter and the arrival stamps
- clk  in  1  sole clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  queue can accept
- in_core  in  3  requesting core ID
- in_opn  in  2  0=data read, 1=data write, 2=instruction fetch, 3=illegal
- in_addr  in  34  physical address
- out_valid  out  1  head entry present
- out_ready  in  1  scheduler consumes head
- out_core  out  3  core of head entry
- out_is_write  out  1  1 iff opn==1
- out_channel  out  1  addr[6]
- out_bank_group  out  3  addr[9:7]
- out_bank  out  2  addr[11:10]
- out_row  out  16  addr[33:18]
- out_column  out  10  {addr[17:12], addr[5:2]}
- out_addr  out  34  original address
- out_enq_cyc  out  CYC_W  cycle counter value at acceptance
- count  out  $clog2(DEPTH+1)  current occupancy
- full, empty  out  1  count==DEPTH / count==0
- err_bad_opn  out  1  one-cycle pulse when an illegal request is dropped

## Operation
- Push: in_valid && in_ready. in_ready = !full, driven combinationally from registered state and independent of out_ready.
- Pop: out_valid && out_ready. out_valid = !empty.
- Decode happens at push. Decoded fields are stored per entry, so out_* come straight from storage with no logic on the out side.
- Opn 2 is stored as a read: out_is_write=0.
- Opn 3 completes the handshake but is not stored. err_bad_opn=1 on the next cycle; count and pointers are unchanged.
- Head and tail pointers are log2(DEPTH) bits and wrap naturally. count is tracked separately, which disambiguates full from empty.
- Push and pop in the same cycle (0<count<DEPTH): both take effect and count is unchanged. This cannot happen at count==DEPTH because in_ready=0 there.
- No bypass: a request pushed into an empty queue appears on out_* one cycle later.
- Cycle counter: starts at 0 and increments every cycle. It wraps modulo 2^CYC_W; no saturation. The stamp is the counter value in the push cycle.
- out_* data fields are don't-care while out_valid=0.
- Reset (at any time): pointers=0, count=0, counter=0. Outputs go to empty=1, full=0, in_ready=1, out_valid=0, err_bad_opn=0, count=0. Entry contents are not cleared, and any in-flight request is lost.

## Timing
- Push at edge N: entry visible with out_valid=1 after edge N (latency 1); count updates after edge N.
- Pop at edge N: the next entry is presented after edge N.
- Full at edge N: in_ready=0 until the cycle after the first pop.
- Throughput: one push and one pop per cycle in steady state.
- err_bad_opn: high exactly one cycle, in the cycle after the illegal push.

## Structure
- Shared package mc_pkg holds:
  - opn_t enum: OPN_RD=0, OPN_WR=1, OPN_IF=2
  - address field bit-position constants
  - mc_req_t packed struct: core, is_write, channel, bank_group, bank, row, column, addr, enq_cyc
  - The scheduler consumes the same mc_req_t.
- One sub-module, mc_addr_decode: a combinational function of addr and opn producing mc_req_t minus the stamp. It is shared with any future multi-channel mapper.
- Storage is a plain register array of mc_req_t [DEPTH].

## Test plan
- Reset: assert rst 3 cycles mid-traffic -> next cycle empty=1, count=0, out_valid=0, in_ready=1, err_bad_opn=0.
- Decode: push opn=0, core=5, addr=34'h1_2345_6789 at counter=7 -> next cycle out_valid=1, channel=0, bank_group=7, bank=1, row=16'h48D1, column=10'h162, is_write=0, enq_cyc=7.
- Fill: out_ready=0, 17 back-to-back pushes -> count reaches 16, full=1, in_ready=0 on the 17th. One pop -> in_ready=1 the next cycle; the 17th is accepted and order is preserved.
- Simultaneous: at count=8, push and pop together for 20 cycles -> count stays 8 and the output sequence matches push order across pointer wrap.
- Illegal opn: push opn=3 into an empty queue -> err_bad_opn pulses one cycle, empty stays 1, and the following legal push is unaffected.
- Opn 2: push opn=2 -> is_write=0; popped in FIFO order with the surrounding writes.
